// File: rtl/exp_ctrl_pkg.sv
// Shared state encoding and Q16.16 constants for the exp(-x) unit arbiter.
package exp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BYPASS = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4,
    GAP    = 3'd5
  } state_t;

  localparam logic [31:0] ONE_Q16 = 32'h0001_0000;
  localparam logic [31:0] SAT_Q16 = 32'h000B_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             found
);

  logic [IW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/exp_arbiter.sv
// Shares one exp(-x) shift-and-subtract unit among N_REQ requesters with
// round-robin grant, trivial-argument bypass and a WAIT timeout.
module exp_arbiter
  import exp_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      svm_enable,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*IN_WIDTH-1:0] req_arg,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [OUT_WIDTH-1:0]      rsp_data,
  output logic                      rsp_err,
  output logic                      exp_enable,
  output logic                      exp_svm_enable,
  output logic [IN_WIDTH-1:0]       exp_sum_a,
  input  logic [OUT_WIDTH-1:0]      exp_out_b,
  input  logic                      exp_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        id_q;
  logic [IW-1:0]        win_idx;
  logic [N_REQ-1:0]     win_grant;
  logic                 win_found;
  logic [IN_WIDTH-1:0]  win_arg;
  logic [IN_WIDTH-1:0]  arg_q;
  logic [TW-1:0]        tcnt;
  logic [N_REQ-1:0]     rsp_valid_q;
  logic                 rsp_err_q;
  logic [N_REQ-1:0]     owner_oh;

  function automatic logic is_bypass(input logic [IN_WIDTH-1:0] a);
    return (a == '0) || (a > IN_WIDTH'(SAT_Q16));
  endfunction

  function automatic logic [OUT_WIDTH-1:0] bypass_data(input logic [IN_WIDTH-1:0] a);
    return (a == '0) ? OUT_WIDTH'(ONE_Q16) : '0;
  endfunction

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .found (win_found)
  );

  assign win_arg        = req_arg[int'(win_idx)*IN_WIDTH +: IN_WIDTH];
  assign owner_oh       = N_REQ'(1) << id_q;
  assign req_ready      = (state == IDLE && svm_enable && !rst) ? win_grant : '0;
  // Pulses are held while frozen and only shown once svm_enable returns.
  assign rsp_valid      = svm_enable ? rsp_valid_q : '0;
  assign rsp_err        = svm_enable & rsp_err_q;
  assign exp_svm_enable = svm_enable;
  assign exp_sum_a      = arg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      id_q        <= '0;
      arg_q       <= '0;
      tcnt        <= '0;
      exp_enable  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data    <= '0;
    end else if (svm_enable) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            ptr  <= (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
            id_q <= win_idx;
            if (is_bypass(win_arg)) begin
              rsp_data <= bypass_data(win_arg);
              state    <= BYPASS;
            end else begin
              arg_q      <= win_arg;
              exp_enable <= 1'b1;
              state      <= LAUNCH;
            end
          end
        end
        BYPASS: begin
          rsp_valid_q <= owner_oh;
          state       <= IDLE;
        end
        LAUNCH: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (!exp_busy) begin
            rsp_data    <= exp_out_b;
            rsp_valid_q <= owner_oh;
            exp_enable  <= 1'b0;
            state       <= RESP;
          end else if (tcnt == TW'(TIMEOUT-1)) begin
            rsp_data    <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_oh;
            exp_enable  <= 1'b0;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_arbiter.sv
// Bench for exp_arbiter: behavioural exp unit / stuck-busy stub, a job-timeline model, directed tests.
module tb_exp_arbiter;

  localparam int N   = 4;
  localparam int NB  = $clog2(N);
  localparam int W   = 32;
  localparam int TO  = 64;
  localparam int LAT = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           svm_enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_arg;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           exp_enable;
  logic           exp_svm_enable;
  logic [W-1:0]   exp_sum_a;
  logic [W-1:0]   exp_out_b;
  logic           exp_busy;

  logic           use_stub;
  logic           u_busy;
  logic [W-1:0]   u_out;
  int             u_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Job-timeline model state
  logic         m_job, m_byp, m_en, r_pend, r_err;
  int           m_k, m_tail, m_owner, m_ptr, r_cnt, r_owner;
  logic [W-1:0] m_arg, r_data;

  // Observation logs
  int g_cyc[$];
  int g_idx[$];
  int r_cyc[$];
  int r_own[$];
  int r_dat[$];
  int r_er[$];
  int en_cycles = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_arbiter #(.N_REQ(N), .IN_WIDTH(W), .OUT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .svm_enable     (svm_enable),
    .req_valid      (req_valid),
    .req_arg        (req_arg),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .exp_enable     (exp_enable),
    .exp_svm_enable (exp_svm_enable),
    .exp_sum_a      (exp_sum_a),
    .exp_out_b      (exp_out_b),
    .exp_busy       (exp_busy)
  );

  function automatic logic [31:0] exp_q16(input logic [31:0] a);
    real x;
    x = real'(a) / 65536.0;
    return 32'($rtoi($exp(-x) * 65536.0 + 0.5));
  endfunction

  // Behavioural exp unit: busy while idle/computing, drops after LAT enabled cycles.
  always @(posedge clk) begin
    if (!exp_enable) begin
      u_cnt  <= 0;
      u_busy <= 1'b1;
    end else if (exp_svm_enable) begin
      if (u_cnt == LAT) begin
        u_busy <= 1'b0;
        u_out  <= exp_q16(exp_sum_a);
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end

  assign exp_busy  = use_stub ? 1'b1 : u_busy;
  assign exp_out_b = use_stub ? 32'hDEAD_BEEF : u_out;

  function automatic int pick(input logic [N-1:0] v, input int p);
    logic [NB-1:0] j;
    for (int i = 0; i < N; i++) begin
      j = NB'((p + i) % N);
      if (v[j]) return int'(j);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    if (i < 0) return '0;
    return N'(1) << i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic [N-1:0] e_rdy, e_rsp;
    logic [W-1:0] a;
    int w;
    if (rst) begin
      m_job = 1'b0; m_byp = 1'b0; m_en = 1'b0; m_ptr = 0; m_k = 0; m_tail = 0;
      r_pend = 1'b0; r_cnt = 0; m_arg = '0;
    end else begin
      w     = pick(req_valid, m_ptr);
      e_rdy = (svm_enable && !m_job) ? onehot(w) : '0;
      e_rsp = (svm_enable && r_pend && r_cnt == 0) ? onehot(r_owner) : '0;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("rsp_err", 32'(rsp_err), (e_rsp != 0) ? 32'(r_err) : 32'd0);
      if (e_rsp != 0) chk("rsp_data", rsp_data, r_data);
      chk("exp_enable", 32'(exp_enable), 32'(m_en));
      if (m_en) chk("exp_sum_a", exp_sum_a, m_arg);
      chk("exp_svm_enable", 32'(exp_svm_enable), 32'(svm_enable));
      if (req_ready != 0)
        for (int i = 0; i < N; i++) if (req_ready[i]) begin g_cyc.push_back(cyc); g_idx.push_back(i); end
      if (rsp_valid != 0)
        for (int i = 0; i < N; i++) if (rsp_valid[i]) begin
          r_cyc.push_back(cyc); r_own.push_back(i); r_dat.push_back(int'(rsp_data)); r_er.push_back(int'(rsp_err));
        end
      if (exp_enable) en_cycles++;
      if (svm_enable) begin
        if (r_pend) begin
          if (r_cnt == 0) r_pend = 1'b0;
          else r_cnt--;
        end
        if (m_job) begin
          if (m_byp) m_job = 1'b0;
          else if (m_tail > 0) begin
            m_tail--;
            if (m_tail == 0) m_job = 1'b0;
          end else if (m_k >= 2 && (!exp_busy || m_k == TO + 1)) begin
            r_pend = 1'b1; r_cnt = 0; r_owner = m_owner;
            r_err  = exp_busy;
            r_data = exp_busy ? '0 : exp_out_b;
            m_en   = 1'b0; m_tail = 2;
          end else m_k++;
        end else if (w >= 0) begin
          a       = req_arg[w*W +: W];
          m_ptr   = (w + 1) % N;
          m_owner = w;
          m_job   = 1'b1;
          if (a == 0 || a > 32'h000B_0000) begin
            m_byp = 1'b1; r_pend = 1'b1; r_cnt = 1; r_owner = w; r_err = 1'b0;
            r_data = (a == 0) ? 32'h0001_0000 : 32'h0;
          end else begin
            m_byp = 1'b0; m_k = 1; m_tail = 0; m_arg = a; m_en = 1'b1;
          end
        end
      end
    end
  end

  task automatic set_arg(input int i, input logic [W-1:0] v);
    req_arg[i*W +: W] = v;
  endtask

  task automatic issue(input logic [N-1:0] mask);
    logic [N-1:0] pend, got;
    int b;
    pend = mask;
    req_valid = req_valid | mask;
    b = 0;
    while (pend != 0 && b < 400) begin
      @(negedge clk);
      got = req_ready & pend;
      @(posedge clk); #1;
      req_valid = req_valid & ~got;
      pend = pend & ~got;
      b++;
    end
    if (pend != 0) begin
      checks++; errors++;
      $display("FAIL issue_accept: pending %b, required none", pend);
      req_valid = req_valid & ~pend;
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((m_job || r_pend) && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (m_job || r_pend) begin
      checks++; errors++;
      $display("FAIL wait_idle: job still open after %0d cycles, required done", b);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_near(input string nm, input int act, input int target);
    int d;
    d = act - target;
    checks++;
    if (d > 64 || d < -64) begin
      errors++;
      $display("FAIL %s: got %h required %h +/-64", nm, act, target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ng, nr, en0, tg;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; svm_enable = 1'b1; req_valid = '0; req_arg = '0; use_stub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    chk("reset_exp_enable", 32'(exp_enable), 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_exp_sum_a", exp_sum_a, 0);
    @(posedge clk); #1;

    // All four requesting continuously: grants must rotate 0,1,2,3,0
    for (int i = 0; i < N; i++) set_arg(i, 32'h0000_8000);
    ng = g_idx.size();
    req_valid = '1;
    for (int b = 0; b < 2000 && g_idx.size() < ng + 5; b++) @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    chk("rr_count", 32'(g_idx.size() - ng), 5);
    if (g_idx.size() >= ng + 5)
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", 32'(g_idx[ng+k]), 32'(exp_ord[k]));
        if (k < 4) chk("rr_spacing_ok", 32'(g_cyc[ng+k+1] - g_cyc[ng+k] >= 5), 1);
      end

    // exp(-1) through the unit
    set_arg(0, 32'h0001_0000);
    nr = r_cyc.size();
    issue(4'b0001);
    wait_idle();
    chk("exp1_rsp_count", 32'(r_cyc.size() - nr), 1);
    if (r_cyc.size() == nr + 1) begin
      chk("exp1_owner", 32'(r_own[nr]), 0);
      chk("exp1_err", 32'(r_er[nr]), 0);
      chk_near("exp1_data", r_dat[nr], 32'h5E2D);
    end

    // Bypass pair: arg 0 and arg above 11.0, unit never enabled
    set_arg(2, 32'h0);
    set_arg(3, 32'h000C_0000);
    ng = g_idx.size(); nr = r_cyc.size(); en0 = en_cycles;
    issue(4'b1100);
    wait_idle();
    chk("byp_rsp_count", 32'(r_cyc.size() - nr), 2);
    if (r_cyc.size() == nr + 2 && g_idx.size() == ng + 2) begin
      chk("byp_first_grant", 32'(g_idx[ng]), 2);
      chk("byp_second_grant", 32'(g_idx[ng+1]), 3);
      chk("byp_grant_spacing", 32'(g_cyc[ng+1] - g_cyc[ng]), 2);
      chk("byp0_owner", 32'(r_own[nr]), 2);
      chk("byp0_data", 32'(r_dat[nr]), 32'h0001_0000);
      chk("byp0_latency", 32'(r_cyc[nr] - g_cyc[ng]), 2);
      chk("bypsat_owner", 32'(r_own[nr+1]), 3);
      chk("bypsat_data", 32'(r_dat[nr+1]), 0);
      chk("bypsat_latency", 32'(r_cyc[nr+1] - g_cyc[ng+1]), 2);
    end
    chk("byp_exp_enable_cycles", 32'(en_cycles - en0), 0);

    // Stuck-busy stub with a 10-cycle freeze inside WAIT: timeout stretched by the freeze
    use_stub = 1'b1;
    set_arg(1, 32'h0002_0000);
    nr = r_cyc.size();
    issue(4'b0010);
    tg = g_cyc[g_cyc.size()-1];
    repeat (20) @(posedge clk);
    #1 svm_enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 svm_enable = 1'b1;
    wait_idle();
    chk("tmo_rsp_count", 32'(r_cyc.size() - nr), 1);
    if (r_cyc.size() == nr + 1) begin
      chk("tmo_err", 32'(r_er[nr]), 1);
      chk("tmo_data", 32'(r_dat[nr]), 0);
      chk("tmo_latency", 32'(r_cyc[nr] - (tg + 2)), TO + 10);
    end

    // Next job after a timeout runs normally: exp(-0.5)
    use_stub = 1'b0;
    set_arg(2, 32'h0000_8000);
    nr = r_cyc.size();
    issue(4'b0100);
    wait_idle();
    chk("after_tmo_count", 32'(r_cyc.size() - nr), 1);
    if (r_cyc.size() == nr + 1) begin
      chk("after_tmo_err", 32'(r_er[nr]), 0);
      chk_near("after_tmo_data", r_dat[nr], 32'h9B45);
    end

    // Freeze mid-WAIT on the real unit
    set_arg(0, 32'h0001_0000);
    nr = r_cyc.size();
    issue(4'b0001);
    tg = g_cyc[g_cyc.size()-1];
    repeat (4) @(posedge clk);
    #1 svm_enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 svm_enable = 1'b1;
    wait_idle();
    chk("frz_rsp_count", 32'(r_cyc.size() - nr), 1);
    if (r_cyc.size() == nr + 1) begin
      chk("frz_err", 32'(r_er[nr]), 0);
      chk_near("frz_data", r_dat[nr], 32'h5E2D);
      chk("frz_latency_stretched", 32'(r_cyc[nr] - tg >= 14), 1);
    end

    // Reset mid-WAIT: job dropped, no response
    set_arg(3, 32'h0001_8000);
    issue(4'b1000);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    nr = r_cyc.size();
    @(negedge clk);
    chk("rstmid_exp_enable", 32'(exp_enable), 0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
    chk("rstmid_exp_sum_a", exp_sum_a, 0);
    chk("rstmid_rsp_data", rsp_data, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("rstmid_no_rsp", 32'(r_cyc.size() - nr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
